ped_request_ctrl: RTL and testbench



---
 rtl/ped_request_ctrl.sv | 131 +++++++++++++
 tb/tb_ped_request_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button front end: synchronise, debounce, latch a service request
// and sequence it through the light controller's ack/done handshake plus a cooldown.
module ped_request_ctrl #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_GAP         = 8,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_raw,
    input  logic       i_svc_ack,
    input  logic       i_svc_done,
    output logic       o_ped_req,
    output logic       o_wait_led,
    output logic       o_btn_pulse,
    output logic [3:0] o_press_cnt,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPending  = 2'd1,
        StServing  = 2'd2,
        StCooldown = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DbLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLoad = CNT_W'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);
    localparam bit               HasGap  = (MIN_GAP > 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_db;
    logic                   r_db_prev;
    logic [CNT_W-1:0]       r_db_cnt;
    logic                   r_btn_pulse;
    state_e                 r_state;
    logic                   r_ped_req;
    logic                   r_wait_led;
    logic [3:0]             r_press_cnt;
    logic [CNT_W-1:0]       r_gap_cnt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
        end
    end

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db        <= 1'b0;
            r_db_prev   <= 1'b0;
            r_db_cnt    <= '0;
            r_btn_pulse <= 1'b0;
        end else begin
            r_db_prev   <= r_db;
            r_btn_pulse <= r_db & ~r_db_prev;
            if (w_s == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DbLast) begin
                r_db     <= w_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_ped_req   <= 1'b0;
            r_wait_led  <= 1'b0;
            r_press_cnt <= 4'd0;
            r_gap_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_btn_pulse) begin
                        r_state     <= StPending;
                        r_ped_req   <= 1'b1;
                        r_wait_led  <= 1'b1;
                        r_press_cnt <= 4'd1;
                    end
                end
                StPending: begin
                    // Ack takes priority over a coincident press.
                    if (i_svc_ack) begin
                        r_ped_req  <= 1'b0;
                        r_wait_led <= 1'b0;
                        if (i_svc_done) begin
                            r_state   <= HasGap ? StCooldown : StIdle;
                            r_gap_cnt <= GapLoad;
                        end else begin
                            r_state <= StServing;
                        end
                    end else if (r_btn_pulse && (r_press_cnt != 4'd15)) begin
                        r_press_cnt <= r_press_cnt + 4'd1;
                    end
                end
                StServing: begin
                    if (i_svc_done) begin
                        r_state   <= HasGap ? StCooldown : StIdle;
                        r_gap_cnt <= GapLoad;
                    end
                end
                StCooldown: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ped_req   = r_ped_req;
    assign o_wait_led  = r_wait_led;
    assign o_btn_pulse = r_btn_pulse;
    assign o_press_cnt = r_press_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed self-checking bench for ped_request_ctrl with default parameters.
module tb_ped_request_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       svc_ack;
    logic       svc_done;
    logic       ped_req;
    logic       wait_led;
    logic       btn_pulse;
    logic [3:0] press_cnt;
    logic [1:0] state;

    int n_checks;
    int n_fails;

    ped_request_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_raw   (btn_raw),
        .i_svc_ack   (svc_ack),
        .i_svc_done  (svc_done),
        .o_ped_req   (ped_req),
        .o_wait_led  (wait_led),
        .o_btn_pulse (btn_pulse),
        .o_press_cnt (press_cnt),
        .o_state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge; land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean press: long enough to debounce, then long enough to debounce the release.
    task automatic press();
        btn_raw = 1'b1;
        repeat (10) tick();
        btn_raw = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        btn_raw  = 1'b0;
        svc_ack  = 1'b0;
        svc_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_ped_req", 32'(ped_req), 0);
        check_eq("rst_wait_led", 32'(wait_led), 0);
        check_eq("rst_pulse", 32'(btn_pulse), 0);
        check_eq("rst_cnt", 32'(press_cnt), 0);
        rst = 1'b0;
        tick();

        // Bounce: 3-cycle highs, 1-cycle lows never reach the debounce threshold.
        for (int i = 0; i < 40; i++) begin
            btn_raw = ((i % 4) != 3);
            tick();
            check_eq("bounce_pulse", 32'(btn_pulse), 0);
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        check_eq("bounce_state", 32'(state), 0);

        // Clean press latency.
        btn_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("clean_pulse", 32'(btn_pulse), (k == 7) ? 1 : 0);
            check_eq("clean_req", 32'(ped_req), (k == 8) ? 1 : 0);
        end
        check_eq("clean_wait", 32'(wait_led), 1);
        check_eq("clean_state", 32'(state), 1);
        check_eq("clean_cnt", 32'(press_cnt), 1);
        btn_raw = 1'b0;
        repeat (10) tick();

        // Handshake with counted presses.
        repeat (3) press();
        check_eq("hs_cnt4", 32'(press_cnt), 4);
        check_eq("hs_state_pend", 32'(state), 1);
        check_eq("hs_svc_done_ignored_req", 32'(ped_req), 1);

        // Press coincident with ack: ack wins, press not counted.
        btn_raw = 1'b1;
        repeat (7) tick();
        check_eq("prio_pulse", 32'(btn_pulse), 1);
        svc_ack = 1'b1;
        tick();
        svc_ack = 1'b0;
        check_eq("prio_state", 32'(state), 2);
        check_eq("prio_cnt", 32'(press_cnt), 4);
        check_eq("prio_req", 32'(ped_req), 0);
        check_eq("prio_wait", 32'(wait_led), 0);
        btn_raw = 1'b0;
        repeat (10) tick();

        press();
        check_eq("serving_ignore_state", 32'(state), 2);
        check_eq("serving_ignore_cnt", 32'(press_cnt), 4);

        // Cooldown lasts 8 cycles; a press debounced inside it is dropped.
        btn_raw  = 1'b1;
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        check_eq("cool_enter", 32'(state), 3);
        for (int k = 2; k <= 8; k++) begin
            tick();
            check_eq("cool_state", 32'(state), 3);
            check_eq("cool_pulse", 32'(btn_pulse), (k == 7) ? 1 : 0);
        end
        tick();
        check_eq("cool_exit", 32'(state), 0);
        check_eq("cool_cnt_hold", 32'(press_cnt), 4);
        repeat (10) tick();
        check_eq("held_no_retrigger", 32'(state), 0);
        btn_raw = 1'b0;
        repeat (10) tick();

        // Saturation.
        repeat (20) press();
        check_eq("sat_cnt", 32'(press_cnt), 15);
        check_eq("sat_req", 32'(ped_req), 1);

        // Ack and done in the same cycle go straight to cooldown.
        svc_ack  = 1'b1;
        svc_done = 1'b1;
        tick();
        svc_ack  = 1'b0;
        svc_done = 1'b0;
        check_eq("ackdone_state", 32'(state), 3);
        check_eq("ackdone_req", 32'(ped_req), 0);
        repeat (8) tick();
        check_eq("ackdone_idle", 32'(state), 0);

        // Ack and done in idle do nothing.
        svc_ack = 1'b1;
        tick();
        svc_ack  = 1'b0;
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        check_eq("idle_ack_state", 32'(state), 0);
        check_eq("idle_ack_req", 32'(ped_req), 0);
        check_eq("idle_ack_cnt", 32'(press_cnt), 15);

        // Asynchronous reset in PENDING clears outputs before the next edge.
        press();
        check_eq("pre_rst_state", 32'(state), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_state", 32'(state), 0);
        check_eq("arst_req", 32'(ped_req), 0);
        check_eq("arst_wait", 32'(wait_led), 0);
        check_eq("arst_cnt", 32'(press_cnt), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_eq("post_rst_state", 32'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
